// File: rtl/pt_wr_sched_if.sv
// Request/strobe bundle between the PT write scheduler and its requesters
// (CSH/MBOX refill, EBOX WR PT, APR sweep) and the PAG write port.
interface pt_wr_sched_if;
  // pgrf_req and ebox_req are levels held until pgrf_done / ebox_ack pulse.
  // A beat is taken in any cycle the refill is granted and pgrf_valid=1.
  // sweep_req is a one-cycle pulse.
  // Every output is registered and shows the decision made on the previous edge.
  logic        pgrf_req;
  logic [7:0]  pgrf_base;
  logic        pgrf_valid;
  logic [35:0] pgrf_data;
  logic        pgrf_done;
  logic        ebox_req;
  logic [8:0]  ebox_adr;
  logic        ebox_both;
  logic [35:0] ebox_data;
  logic        ebox_ack;
  logic        sweep_req;
  logic        sweep_busy;
  logic        pt_we;
  logic        pt_left_en;
  logic        pt_right_en;
  logic [7:0]  pt_adr;
  logic [35:0] pt_din;
  logic        dir_we;
  logic        dir_clr;
  logic [6:0]  dir_adr;
  logic [1:0]  dbg_state;

  modport master (
    output pgrf_req, pgrf_base, pgrf_valid, pgrf_data,
    output ebox_req, ebox_adr, ebox_both, ebox_data, sweep_req,
    input  pgrf_done, ebox_ack, sweep_busy,
    input  pt_we, pt_left_en, pt_right_en, pt_adr, pt_din,
    input  dir_we, dir_clr, dir_adr, dbg_state
  );

  modport slave (
    input  pgrf_req, pgrf_base, pgrf_valid, pgrf_data,
    input  ebox_req, ebox_adr, ebox_both, ebox_data, sweep_req,
    output pgrf_done, ebox_ack, sweep_busy,
    output pt_we, pt_left_en, pt_right_en, pt_adr, pt_din,
    output dir_we, dir_clr, dir_adr, dbg_state
  );
endinterface

// File: rtl/pt_wr_sched.sv
// Page table / directory write scheduler: arbitrates refill bursts, single
// EBOX PT writes and the directory invalidate sweep onto one write port.
module pt_wr_sched #(
  parameter int DIR_ENTRIES  = 128,
  parameter int REFILL_BEATS = 4
) (
  input  logic           clk,
  input  logic           CROBAR,
  pt_wr_sched_if.slave   bus
);

  localparam int SW = $clog2(DIR_ENTRIES);
  localparam logic [SW-1:0] S_LAST    = SW'(DIR_ENTRIES - 1);
  localparam logic [1:0]    B_LAST    = 2'(REFILL_BEATS - 1);
  localparam logic [7:0]    BEAT_MASK = 8'(REFILL_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    EBOX   = 2'd2,
    SWEEP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    b_q, b_d;
  logic [SW-1:0] s_q, s_d;
  logic          pending_q, pending_d;
  logic          done_pend_q, done_pend_d;

  logic          pt_we_q, pt_we_d;
  logic          pt_left_q, pt_left_d;
  logic          pt_right_q, pt_right_d;
  logic [7:0]    pt_adr_q, pt_adr_d;
  logic [35:0]   pt_din_q, pt_din_d;
  logic          dir_we_q, dir_we_d;
  logic          dir_clr_q, dir_clr_d;
  logic [6:0]    dir_adr_q, dir_adr_d;
  logic          pgrf_done_q, pgrf_done_d;
  logic          ebox_ack_q, ebox_ack_d;
  logic          busy_q, busy_d;

  logic          beat_fire;
  logic [1:0]    beat_idx;
  logic          final_clr;

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    s_d         = s_q;
    done_pend_d = done_pend_q;
    pending_d   = pending_q | bus.sweep_req;
    pt_we_d     = 1'b0;
    pt_left_d   = 1'b0;
    pt_right_d  = 1'b0;
    pt_adr_d    = '0;
    pt_din_d    = '0;
    dir_we_d    = 1'b0;
    dir_clr_d   = 1'b0;
    dir_adr_d   = '0;
    pgrf_done_d = 1'b0;
    ebox_ack_d  = 1'b0;
    beat_fire   = 1'b0;
    beat_idx    = 2'd0;
    final_clr   = 1'b0;

    case (state_q)
      // IDLE and SWEEP share arbitration so a sweep yields between entries.
      // pgrf_req is masked while pgrf_done shows, since the requester only
      // drops it once it has seen the pulse.
      IDLE, SWEEP: begin
        if (bus.pgrf_req && !pgrf_done_q) begin
          state_d     = REFILL;
          b_d         = 2'd0;
          done_pend_d = 1'b0;
          beat_fire   = bus.pgrf_valid;
        end else if (bus.ebox_req) begin
          state_d    = EBOX;
          pt_we_d    = 1'b1;
          pt_left_d  = bus.ebox_both | ~bus.ebox_adr[0];
          pt_right_d = bus.ebox_both |  bus.ebox_adr[0];
          pt_adr_d   = bus.ebox_adr[8:1];
          pt_din_d   = bus.ebox_data;
          ebox_ack_d = 1'b1;
        end else if (pending_q) begin
          dir_we_d  = 1'b1;
          dir_clr_d = 1'b1;
          dir_adr_d = 7'(s_q);
          s_d       = s_q + 1'b1;
          if (s_q == S_LAST) begin
            final_clr = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = SWEEP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (done_pend_q) begin
          pgrf_done_d = 1'b1;
          done_pend_d = 1'b0;
          state_d     = IDLE;
        end else begin
          beat_fire = bus.pgrf_valid;
          beat_idx  = b_q;
        end
      end
      EBOX: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (beat_fire) begin
      pt_we_d    = 1'b1;
      pt_left_d  = 1'b1;
      pt_right_d = 1'b1;
      pt_adr_d   = (bus.pgrf_base & ~BEAT_MASK) | {6'b0, beat_idx};
      pt_din_d   = bus.pgrf_data;
      dir_we_d   = 1'b1;
      dir_adr_d  = pt_adr_d[7:1];
      if (beat_idx == B_LAST) begin
        done_pend_d = 1'b1;
        b_d         = 2'd0;
      end else begin
        b_d = beat_idx + 2'd1;
      end
    end

    // A request landing on the final entry is absorbed into this sweep.
    if (final_clr) pending_d = 1'b0;
    busy_d = pending_d | final_clr;
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q     <= IDLE;
      b_q         <= '0;
      s_q         <= '0;
      pending_q   <= 1'b0;
      done_pend_q <= 1'b0;
      pt_we_q     <= 1'b0;
      pt_left_q   <= 1'b0;
      pt_right_q  <= 1'b0;
      pt_adr_q    <= '0;
      pt_din_q    <= '0;
      dir_we_q    <= 1'b0;
      dir_clr_q   <= 1'b0;
      dir_adr_q   <= '0;
      pgrf_done_q <= 1'b0;
      ebox_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      s_q         <= s_d;
      pending_q   <= pending_d;
      done_pend_q <= done_pend_d;
      pt_we_q     <= pt_we_d;
      pt_left_q   <= pt_left_d;
      pt_right_q  <= pt_right_d;
      pt_adr_q    <= pt_adr_d;
      pt_din_q    <= pt_din_d;
      dir_we_q    <= dir_we_d;
      dir_clr_q   <= dir_clr_d;
      dir_adr_q   <= dir_adr_d;
      pgrf_done_q <= pgrf_done_d;
      ebox_ack_q  <= ebox_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.pt_we       = pt_we_q;
  assign bus.pt_left_en  = pt_left_q;
  assign bus.pt_right_en = pt_right_q;
  assign bus.pt_adr      = pt_adr_q;
  assign bus.pt_din      = pt_din_q;
  assign bus.dir_we      = dir_we_q;
  assign bus.dir_clr     = dir_clr_q;
  assign bus.dir_adr     = dir_adr_q;
  assign bus.pgrf_done   = pgrf_done_q;
  assign bus.ebox_ack    = ebox_ack_q;
  assign bus.sweep_busy  = busy_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pt_wr_sched.sv
// Directed bench for pt_wr_sched: refill, EBOX, sweep with preemption and
// reset mid-operation; every observed write is matched against expected queues.
module tb_pt_wr_sched;

  logic clk = 1'b0;
  logic CROBAR;

  pt_wr_sched_if bus();

  pt_wr_sched #(.DIR_ENTRIES(128), .REFILL_BEATS(4)) dut (
    .clk    (clk),
    .CROBAR (CROBAR),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int clr_cnt  = 0;
  int fall_cnt = 0;
  logic busy_prev = 1'b0;

  // {tag bit, left, right, adr, din} and {tag bit, clr, adr}
  logic [46:0] pt_exp_q[$];
  logic [8:0]  dir_exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of its queue
  always @(negedge clk) begin
    logic [46:0] pt_exp;
    logic [8:0]  dir_exp;
    if (bus.pt_we) begin
      pt_exp = (pt_exp_q.size() > 0) ? pt_exp_q.pop_front() : '0;
      check("pt_wr", {1'b1, bus.pt_left_en, bus.pt_right_en, bus.pt_adr, bus.pt_din}, pt_exp);
    end
    if (bus.dir_we) begin
      dir_exp = (dir_exp_q.size() > 0) ? dir_exp_q.pop_front() : '0;
      check("dir_wr", {1'b1, bus.dir_clr, bus.dir_adr}, dir_exp);
    end
    if (bus.pt_we || bus.dir_we)
      check("excl", bus.pt_we & bus.dir_we & bus.dir_clr, 0);
    if (bus.dir_we && bus.dir_clr) clr_cnt++;
    if (busy_prev && !bus.sweep_busy) fall_cnt++;
    busy_prev = bus.sweep_busy;
  end

  task automatic check_quiet(input string tag);
    check({tag, "_pt_we"},     bus.pt_we,       0);
    check({tag, "_left"},      bus.pt_left_en,  0);
    check({tag, "_right"},     bus.pt_right_en, 0);
    check({tag, "_pt_adr"},    bus.pt_adr,      0);
    check({tag, "_pt_din"},    bus.pt_din,      0);
    check({tag, "_dir_we"},    bus.dir_we,      0);
    check({tag, "_dir_clr"},   bus.dir_clr,     0);
    check({tag, "_dir_adr"},   bus.dir_adr,     0);
    check({tag, "_pgrf_done"}, bus.pgrf_done,   0);
    check({tag, "_ebox_ack"},  bus.ebox_ack,    0);
    check({tag, "_busy"},      bus.sweep_busy,  0);
    check({tag, "_state"},     bus.dbg_state,   0);
  endtask

  // driver: refill burst, data of beat k is seed*(k+1)
  task automatic do_refill(input logic [7:0] base, input logic [35:0] seed,
                           input int gap_beat, input int gap_len, input int rst_beat);
    logic [35:0] d;
    logic [7:0]  adr;
    bus.pgrf_req  = 1'b1;
    bus.pgrf_base = base;
    for (int beat = 0; beat < 4; beat++) begin
      if (beat == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.pgrf_valid = 1'b0;
          @(negedge clk);
          check("gap_pt_we", bus.pt_we, 0);
          check("gap_dir_we", bus.dir_we, 0);
        end
      end
      d = 36'(seed * 36'(beat + 1));
      bus.pgrf_valid = 1'b1;
      bus.pgrf_data  = d;
      if (beat == rst_beat) begin
        CROBAR = 1'b1;
        @(negedge clk);
        check_quiet("rst_refill");
        CROBAR         = 1'b0;
        bus.pgrf_req   = 1'b0;
        bus.pgrf_valid = 1'b0;
        return;
      end
      adr = {base[7:2], 2'(beat)};
      pt_exp_q.push_back({1'b1, 2'b11, adr, d});
      dir_exp_q.push_back({1'b1, 1'b0, adr[7:1]});
      @(negedge clk);
    end
    bus.pgrf_valid = 1'b0;
    check("done_early", bus.pgrf_done, 0);
    @(negedge clk);
    check("done_pulse", bus.pgrf_done, 1);
    check("done_no_we", bus.pt_we, 0);
    bus.pgrf_req = 1'b0;
    @(negedge clk);
    check("done_width", bus.pgrf_done, 0);
  endtask

  task automatic ebox_start(input logic [8:0] adr, input logic both, input logic [35:0] data);
    bus.ebox_req  = 1'b1;
    bus.ebox_adr  = adr;
    bus.ebox_both = both;
    bus.ebox_data = data;
  endtask

  task automatic ebox_finish(input logic [7:0] idx, input logic l, input logic r);
    logic ok;
    ok = 1'b0;
    pt_exp_q.push_back({1'b1, l, r, idx, bus.ebox_data});
    for (int i = 0; i < 200; i++) begin
      if (bus.ebox_ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ebox_ack_seen", ok, 1);
    check("ebox_ack_we", bus.pt_we, 1);
    check("ebox_no_dir", bus.dir_we, 0);
    bus.ebox_req  = 1'b0;
    bus.ebox_both = 1'b0;
    @(negedge clk);
    check("ebox_ack_width", bus.ebox_ack, 0);
  endtask

  task automatic sweep_pulse();
    bus.sweep_req = 1'b1;
    @(negedge clk);
    bus.sweep_req = 1'b0;
    check("busy_rise", bus.sweep_busy, 1);
  endtask

  task automatic push_clears(input int first, input int last);
    for (int i = first; i <= last; i++) dir_exp_q.push_back({1'b1, 1'b1, 7'(i)});
  endtask

  // wait until clear of entry adr shows; pulse sweep_req again when pulse_at shows
  task automatic wait_clear(input int adr, input int pulse_at);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      bus.sweep_req = (pulse_at >= 0) && bus.dir_we && bus.dir_clr && (int'(bus.dir_adr) == pulse_at);
      if (bus.dir_we && bus.dir_clr && int'(bus.dir_adr) == adr) found = 1'b1;
    end
    bus.sweep_req = 1'b0;
    check("wait_clear", found, 1);
  endtask

  task automatic wait_busy_low();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (!bus.sweep_busy) found = 1'b1;
    end
    check("busy_fall", found, 1);
  endtask

  initial begin
    CROBAR         = 1'b1;
    bus.pgrf_req   = 1'b0;
    bus.pgrf_base  = '0;
    bus.pgrf_valid = 1'b0;
    bus.pgrf_data  = '0;
    bus.ebox_req   = 1'b0;
    bus.ebox_adr   = '0;
    bus.ebox_both  = 1'b0;
    bus.ebox_data  = '0;
    bus.sweep_req  = 1'b0;

    // reset and idle
    repeat (3) @(negedge clk);
    check_quiet("reset");
    CROBAR = 1'b0;
    repeat (10) @(negedge clk);
    check_quiet("idle");

    // refill 0x5E: pt 5C..5F, dir 2E,2E,2F,2F
    do_refill(8'h5E, 36'h111111111, -1, 0, -1);
    check("refill1_pt_q", pt_exp_q.size(), 0);
    check("refill1_dir_q", dir_exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // refill with a 3-cycle valid gap before beat 2
    do_refill(8'hA1, 36'h123456789, 2, 3, -1);
    check("refill2_pt_q", pt_exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // EBOX: right only, left only, both at index 0x52
    ebox_start(9'h0A5, 1'b0, 36'hABCDE0001);
    ebox_finish(8'h52, 1'b0, 1'b1);
    ebox_start(9'h0A4, 1'b0, 36'hABCDE0002);
    ebox_finish(8'h52, 1'b1, 1'b0);
    ebox_start(9'h0A4, 1'b1, 36'hABCDE0003);
    ebox_finish(8'h52, 1'b1, 1'b1);
    check("ebox_pt_q", pt_exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // sweep preempted at s=40 by refill + ebox, with a repeated sweep_req
    clr_cnt  = 0;
    fall_cnt = 0;
    push_clears(0, 39);
    sweep_pulse();
    wait_clear(39, 10);
    ebox_start(9'h1F3, 1'b0, 36'h0F0F0F0F0);
    do_refill(8'h33, 36'h020406081, -1, 0, -1);
    check("pre_resume_busy", bus.sweep_busy, 1);
    push_clears(40, 127);
    ebox_finish(8'hF9, 1'b0, 1'b1);
    wait_busy_low();
    repeat (20) @(negedge clk);
    check("sweep_clr_cnt", clr_cnt, 128);
    check("sweep_fall_cnt", fall_cnt, 1);
    check("sweep_busy_end", bus.sweep_busy, 0);
    check("sweep_dir_q", dir_exp_q.size(), 0);
    check("sweep_pt_q", pt_exp_q.size(), 0);

    // reset at refill beat 2
    do_refill(8'h10, 36'h111111111, -1, 0, 2);
    check("rst_refill_pt_q", pt_exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("rst_refill_quiet", bus.pt_we, 0);

    // reset at sweep s=70, then a fresh sweep from s=0
    push_clears(0, 69);
    sweep_pulse();
    wait_clear(69, -1);
    CROBAR = 1'b1;
    @(negedge clk);
    check_quiet("rst_sweep");
    CROBAR = 1'b0;
    check("rst_sweep_q", dir_exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("rst_sweep_no_resume", bus.dir_we, 0);
    check("rst_sweep_busy", bus.sweep_busy, 0);

    clr_cnt = 0;
    push_clears(0, 127);
    sweep_pulse();
    wait_busy_low();
    repeat (5) @(negedge clk);
    check("restart_clr_cnt", clr_cnt, 128);
    check("restart_dir_q", dir_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pt_wr_sched.md
Name: pt_wr_sched

Overview:
- Schedules every write into the page table RAM (256 x 36, left/right halves) and its 128-entry directory RAM.
- Serves three requesters: the 4-beat page-refill burst from CSH/MBOX, single EBOX WR PT writes, and the full directory sweep/invalidate requested on a user or exec base register change.
- Sits between CSH, APR and the PAG write-enable/address logic and replaces the ad-hoc PGRF_CYC/SEL_1/SEL_2 gating of the PT address.

Parameters:
- DIR_ENTRIES, 128, directory entries visited by one sweep (power of two)
- REFILL_BEATS, 4, PT entries written per refill burst (power of two, at most 4)

Ports:
- clk  in  1  system clock
- CROBAR  in  1  synchronous active-high reset
- pgrf_req  in  1  refill burst request; level, held until pgrf_done
- pgrf_base  in  8  PT index of the burst; low log2(REFILL_BEATS) bits ignored
- pgrf_valid  in  1  refill data beat present on pgrf_data
- pgrf_data  in  36  refill beat data, written to both halves
- pgrf_done  out  1  one-cycle pulse after the last beat is written
- ebox_req  in  1  single PT write request; level, held until ebox_ack
- ebox_adr  in  9  bits [8:1] are the PT index; bit [0] is the half (0 = left, 1 = right)
- ebox_both  in  1  write both halves and ignore ebox_adr[0]
- ebox_data  in  36  write data
- ebox_ack  out  1  one-cycle pulse in the cycle the write is issued
- sweep_req  in  1  one-cycle pulse requesting a directory invalidate
- sweep_busy  out  1  high from sweep acceptance until the sweep completes
- pt_we  out  1  PT write strobe
- pt_left_en  out  1  left-half enable
- pt_right_en  out  1  right-half enable
- pt_adr  out  8  PT index
- pt_din  out  36  PT write data
- dir_we  out  1  directory write strobe
- dir_clr  out  1  write the invalid (cleared) value
- dir_adr  out  7  directory index

Behaviour:
- Reset state: state IDLE. All outputs 0, including sweep_busy. Sweep counter 0, beat counter 0, sweep_pending 0. Reset mid-operation abandons any burst or sweep, and the next cycle is IDLE with no strobes.
- All outputs are registered. Every write strobe is a single-cycle pulse.
- States:
  - IDLE
  - REFILL (beat counter b)
  - EBOX
  - SWEEP (counter s)
- Request capture: sweep_req sets sweep_pending. A second sweep_req while pending or while sweeping is absorbed, giving one sweep.
- Arbitration in IDLE, evaluated each cycle, fixed priority:
  1. pgrf_req
  2. ebox_req
  3. sweep_pending
  - Arbitration also re-runs after each sweep entry, so a sweep is preempted between entries by pgrf_req or ebox_req.
  - A preempted sweep keeps its counter and sweep_busy stays high. The sweep resumes at the same s after the preempting transaction.
- REFILL:
  - On entry b = 0.
  - Each cycle with pgrf_valid=1:
    - pt_we=1, pt_left_en=1, pt_right_en=1
    - pt_adr = {pgrf_base[7:2], b[1:0]}
    - pt_din = pgrf_data
    - dir_we=1, dir_clr=0, dir_adr = pt_adr[7:1]
  - Then b increments.
  - A cycle with pgrf_valid=0 waits with no strobe; there is no timeout.
  - After beat REFILL_BEATS-1: pgrf_done pulses the next cycle, then return to IDLE.
  - pgrf_req dropping mid-burst is a protocol violation, ignored; the burst completes on valid beats.
- EBOX: one cycle.
  - pt_we=1
  - pt_left_en = ebox_both | ~ebox_adr[0]
  - pt_right_en = ebox_both | ebox_adr[0]
  - pt_adr = ebox_adr[8:1], pt_din = ebox_data
  - ebox_ack pulses in the same cycle.
  - The directory is not written.
  - Return to IDLE.
- SWEEP:
  - Each cycle: dir_we=1, dir_clr=1, dir_adr=s, then s increments.
  - pt_we stays 0 throughout.
  - After s = DIR_ENTRIES-1: s wraps to 0, sweep_busy falls the next cycle, sweep_pending clears.
  - A sweep_req arriving in the same cycle as the final entry is absorbed.
  - A sweep_req arriving after sweep_busy falls starts a new sweep.
- Latency:
  - Request seen in IDLE → first strobe next cycle.
  - Uncontended sweep occupies exactly DIR_ENTRIES cycles of strobes.
- Simultaneous pgrf_req and ebox_req: refill wins; ebox waits for the full burst.
- Never more than one requester is strobed in a cycle.
- pt_we and dir_we never both assert with dir_clr=1.

Test Plan:
- Reset then idle 10 cycles → all outputs 0, sweep_busy=0.
- Refill, pgrf_base=0x5E, valid on every cycle, data 0x111111111, 0x222222222, 0x333333333, 0x444444444 → pt_adr 0x5C, 0x5D, 0x5E, 0x5F, both halves enabled each beat; dir_adr 0x2E, 0x2E, 0x2F, 0x2F; pgrf_done one cycle after the fourth beat.
- Refill with valid deasserted on beat 2 for 3 cycles → no strobes during the gap; 4 total writes, correct addresses.
- Three EBOX writes: ebox_adr=0x0A5, then ebox_adr=0x0A4, then ebox_both=1 with ebox_adr=0x0A4 → index 0x52; right only; left only; both. ebox_ack coincides with pt_we each time.
- sweep_req, then at s=40 raise pgrf_req plus ebox_req, with a second sweep_req during the sweep → dir clears 0..39, refill burst, ebox write, clears resume 40..127. Exactly 128 clears total; sweep_busy falls once; no second sweep.
- CROBAR asserted at refill beat 2 and at sweep s=70 → next cycle IDLE, no strobes, sweep_busy=0. A new sweep_req restarts at s=0.
